// File: rtl/mb_pacer_pkg.sv
// Shared types and helpers for the source-domain pacer of the multibit synchronizer.
package mb_pacer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } pacer_state_t;

    // Width of a down-counter that must hold the larger of the two phase lengths.
    function automatic int cnt_width(input int hold, input int gap);
        int max_v;
        max_v = (hold > gap) ? hold : gap;
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/mb_pacer_fifo.sv
// Single-clock FIFO that queues producer words for the pacer.
// The head word is presented combinationally on o_data; the pacer registers it on pop.
module mb_pacer_fifo #(
    parameter int NB         = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clock,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic [NB-1:0]                 i_data,
    output logic [NB-1:0]                 o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);
    import mb_pacer_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [NB-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // A push is only taken when there is room, so push+pop while full drops the push.
    assign push_ok_s = i_push && !o_full;
    assign pop_ok_s  = i_pop && !o_empty;

    assign o_full  = (count_r == LW'(FIFO_DEPTH));
    assign o_empty = (count_r == LW'(0));
    assign o_data  = mem_r[rd_ptr_r];
    assign o_level = count_r;

    // Storage write; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= NB'(0);
            end
            wr_ptr_r <= AW'(0);
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= i_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Read pointer advances on every accepted pop.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_r <= AW'(0);
        end else if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_r <= rd_ptr_r;
        end
    end

    // Occupancy tracking; simultaneous push and pop leave it unchanged.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_r <= LW'(0);
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mb_sync_src_pacer.sv
// Source-domain front end of the multibit synchronizer: queues producer words and
// replays each as an isolated, stretched valid pulse with data held stable, so the
// slower destination edge detector never misses a word.
// Optional build macro: MB_PACER_LEVEL_EN adds the o_level occupancy output.
module mb_sync_src_pacer
    import mb_pacer_pkg::*;
#(
    parameter int NB          = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                          i_clock,
    input  logic                          i_rst_n,
    input  logic [NB-1:0]                 i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic [NB-1:0]                 o_data,
    output logic                          o_valid,
`ifdef MB_PACER_LEVEL_EN
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
`endif
    output logic                          o_busy
);

    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    pacer_state_t  state_r;
    logic [CW-1:0] cnt_r;
    logic [NB-1:0] data_r;
    logic          valid_r;
    logic          pop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [NB-1:0] fifo_rdata_s;
    logic [LW-1:0] fifo_level_s;

    mb_pacer_fifo #(
        .NB         (NB),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_rst_n (i_rst_n),
        .i_push  (i_valid),
        .i_pop   (pop_s),
        .i_data  (i_data),
        .o_data  (fifo_rdata_s),
        .o_full  (fifo_full_s),
        .o_empty (fifo_empty_s),
        .o_level (fifo_level_s)
    );

    // The head is taken only from IDLE, so o_data never changes during a pulse or gap.
    assign pop_s   = (state_r == IDLE) && !fifo_empty_s;
    assign o_ready = !fifo_full_s;
    assign o_busy  = (fifo_level_s != LW'(0)) || (state_r != IDLE);
    assign o_data  = data_r;
    assign o_valid = valid_r;
`ifdef MB_PACER_LEVEL_EN
    assign o_level = fifo_level_s;
`endif

    // Pacing FSM: pop into the data register, hold valid high, then enforce a low gap.
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CW'(0);
            data_r  <= NB'(0);
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!fifo_empty_s) begin
                        data_r  <= fifo_rdata_s;
                        valid_r <= 1'b1;
                        cnt_r   <= CW'(HOLD_CYCLES - 1);
                        state_r <= HOLD;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                HOLD: begin
                    if (cnt_r == CW'(0)) begin
                        valid_r <= 1'b0;
                        cnt_r   <= CW'(GAP_CYCLES - 1);
                        state_r <= GAP;
                    end else begin
                        valid_r <= 1'b1;
                        cnt_r   <= cnt_r - CW'(1);
                    end
                end
                GAP: begin
                    valid_r <= 1'b0;
                    if (cnt_r == CW'(0)) begin
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    cnt_r   <= CW'(0);
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mb_sync_src_pacer.sv
// Scoreboard bench for mb_sync_src_pacer with default parameters and a slow
// destination-domain capture model (2-flop sync + rising-edge detect, 3x slower clock).
module tb_mb_sync_src_pacer;

    localparam int NB   = 8;
    localparam int HOLD = 4;

    logic          clk   = 1'b0;
    logic          dclk  = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic [NB-1:0] i_data  = 8'h00;
    logic          o_ready;
    logic [NB-1:0] o_data;
    logic          o_valid;
    logic          o_busy;
`ifdef MB_PACER_LEVEL_EN
    logic [2:0]    o_level;
`endif

    mb_sync_src_pacer dut (
        .i_clock (clk),
        .i_rst_n (rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
`ifdef MB_PACER_LEVEL_EN
        .o_level (o_level),
`endif
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;
    initial begin
        #2;
        forever #15 dclk = ~dclk;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_acc = 0;
    int dcap_n  = 0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] dexp_q[$];
    int rise_q[$];
    logic rdy_log [64];
    logic rlog_en = 1'b0;
    int   rbase   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Source monitor: pops the scoreboard on every o_valid rising edge.
    initial begin : src_monitor
        logic prev_v;
        logic [NB-1:0] held;
        int hi_len;
        prev_v = 1'b0;
        held   = 8'h00;
        hi_len = 0;
        forever begin
            @(negedge clk);
            if (rlog_en && (cyc - rbase) >= 0 && (cyc - rbase) < 64) rdy_log[cyc - rbase] = o_ready;
            if (!rst_n) begin
                prev_v = 1'b0;
                hi_len = 0;
            end else begin
                if (o_valid && !prev_v) begin
                    rise_q.push_back(cyc);
                    if (exp_q.size() == 0) fail_now("unexpected_word");
                    else check("word_order", o_data, exp_q.pop_front());
                    held   = o_data;
                    hi_len = 1;
                end else if (o_valid) begin
                    hi_len++;
                    check("data_stable", o_data, held);
                end else if (prev_v) begin
                    check("hold_len", hi_len, HOLD);
                end
                prev_v = o_valid;
            end
        end
    end

    // Destination capture model: slow clock, 2-flop sync, capture data on synced rise.
    initial begin : dst_monitor
        logic [2:0] dsync;
        dsync = 3'b000;
        forever begin
            @(posedge dclk);
            if (!rst_n) begin
                dsync = 3'b000;
            end else begin
                dsync = {dsync[1:0], o_valid};
                if (dsync[1] && !dsync[2]) begin
                    dcap_n++;
                    if (dexp_q.size() == 0) fail_now("dest_extra_word");
                    else check("dest_word", o_data, dexp_q.pop_front());
                end
            end
        end
    end

    task automatic push_word(input logic [NB-1:0] w);
        int t;
        i_valid = 1'b1;
        i_data  = w;
        for (t = 0; t < 64; t++) begin
            @(negedge clk);
            if (o_ready) break;
        end
        if (t == 64) begin
            fail_now("push_timeout");
        end else begin
            last_acc = cyc;
            exp_q.push_back(w);
            dexp_q.push_back(w);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic at_neg(input int c);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cyc < c && guard < 1000);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        int n0;
        int d0;

        // Reset with valid held high: nothing may be queued or driven.
        rst_n   = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_o_valid", o_valid, 1'b0);
        check("reset_o_data", o_data, 8'h00);
        check("reset_o_busy", o_busy, 1'b0);
        i_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", o_ready, 1'b1);
        check("busy_after_reset", o_busy, 1'b0);
`ifdef MB_PACER_LEVEL_EN
        check("level_after_reset", o_level, 3'd0);
`endif

        // Single word: pulse in cycles 2..5, busy clears at cycle 10.
        @(posedge clk); #1;
        base = cyc;
        n0   = rise_q.size();
        push_word(8'hA5);
        at_neg(base + 9);
        check("busy_cycle9", o_busy, 1'b1);
        at_neg(base + 10);
        check("busy_cycle10", o_busy, 1'b0);
        check("data_held_idle", o_data, 8'hA5);
        check("single_rise_count", rise_q.size() - n0, 1);
        if (rise_q.size() > n0) check("single_rise_cycle", rise_q[n0] - base, 2);

        // Burst of six: queue fills, full-boundary push retried at cycle 11.
        @(posedge clk); #1;
        base    = cyc;
        n0      = rise_q.size();
        rbase   = base;
        rlog_en = 1'b1;
        for (int i = 0; i < 6; i++) push_word(8'h01 + 8'(i));
        check("full_accept_cycle", last_acc - base, 11);
        at_neg(base + 60);
        rlog_en = 1'b0;
        check("ready_c4", rdy_log[4], 1'b1);
        check("ready_c5_full", rdy_log[5], 1'b0);
        check("ready_c10_pop_while_full", rdy_log[10], 1'b0);
        check("ready_c11", rdy_log[11], 1'b1);
        check("burst_rise_count", rise_q.size() - n0, 6);
        if (rise_q.size() >= n0 + 6) begin
            check("burst_first_rise", rise_q[n0] - base, 2);
            for (int i = 1; i < 6; i++) check("burst_spacing", rise_q[n0 + i] - rise_q[n0 + i - 1], 9);
        end
        check("burst_drained", exp_q.size(), 0);

        // Async reset mid-HOLD with three words queued.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) push_word(8'h11 + 8'(i));
`ifdef MB_PACER_LEVEL_EN
        check("level_three_queued", o_level, 3'd3);
`endif
        check("valid_in_hold", o_valid, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("valid_async_drop", o_valid, 1'b0);
        check("data_async_clear", o_data, 8'h00);
        check("busy_async_clear", o_busy, 1'b0);
        exp_q.delete();
        dexp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        n0 = rise_q.size();
        repeat (30) @(negedge clk);
        check("no_stale_word", rise_q.size() - n0, 0);
        check("busy_after_mid_reset", o_busy, 1'b0);
        check("ready_after_mid_reset", o_ready, 1'b1);

        // End-to-end through the slow destination capture.
        @(posedge clk); #1;
        d0 = dcap_n;
        push_word(8'hC1);
        push_word(8'hC2);
        push_word(8'hC3);
        repeat (50) @(negedge clk);
        check("dest_capture_count", dcap_n - d0, 3);
        check("dest_all_seen", dexp_q.size(), 0);
        check("src_all_seen", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
